instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL signal an instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL carry the word-aligned fetch address.
REQ-006 imem_ack  input  1  SHALL signal that imem_rdata is valid for the outstanding request, in this cycle only.
REQ-007 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-008 redirect  input  1  SHALL request a control-flow change (branch/jump taken).
REQ-009 redirect_pc  input  32  SHALL carry the target address; bits [1:0] ignored.
REQ-010 inst_valid  output  1  SHALL mark inst_out/inst_pc valid toward decode/control.
REQ-011 inst_ready  input  1  SHALL mark that decode/control accepts the instruction this cycle.
REQ-012 inst_out  output  32  SHALL carry the fetched instruction word.
REQ-013 inst_pc  output  32  SHALL carry the address inst_out was fetched from.

Function
REQ-014 The block SHALL implement three states: REQ (request outstanding), HOLD (instruction held for decode), DROP (request outstanding, response to be discarded).
REQ-015 Internal pc SHALL be 32 bits, bits [1:0] always 0; pc+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-016 imem_req SHALL be 1 in REQ and DROP, 0 in HOLD; imem_addr SHALL equal pc in REQ and remain stable until imem_ack.
REQ-017 REQ with imem_ack=1 and redirect=0: inst_out<=imem_rdata, inst_pc<=pc, pc<=pc+4, next state HOLD.
REQ-018 REQ with imem_ack=0 and redirect=0: state and pc SHALL hold.
REQ-019 REQ with imem_ack=1 and redirect=1: imem_rdata SHALL be discarded, pc<={redirect_pc[31:2],2'b00}, next state REQ.
REQ-020 REQ with imem_ack=0 and redirect=1: pc_target<={redirect_pc[31:2],2'b00}, next state DROP; imem_addr SHALL keep the old address.
REQ-021 DROP: imem_ack=1 SHALL discard imem_rdata, load pc from pc_target, next state REQ; a further redirect in DROP SHALL overwrite pc_target (latest wins), including in the ack cycle.
REQ-022 inst_valid SHALL be 1 exactly in HOLD; inst_out and inst_pc SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-023 HOLD with inst_ready=1 and redirect=0: transfer completes, next state REQ (new request issued the following cycle).
REQ-024 HOLD with redirect=1 and inst_ready=0: held instruction SHALL be discarded, pc<={redirect_pc[31:2],2'b00}, next state REQ.
REQ-025 HOLD with redirect=1 and inst_ready=1: transfer SHALL count as completed, pc<={redirect_pc[31:2],2'b00}, next state REQ.
REQ-026 redirect SHALL take priority over sequential pc+4 in every state; no instruction fetched before a redirect SHALL reach inst_valid after the redirect cycle.
REQ-027 Maximum throughput SHALL be one instruction per two cycles with zero-wait memory (ack in request cycle).

Reset
REQ-028 reset_n=0 SHALL immediately force state=REQ, pc=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, and hold imem_req=0 while reset_n=0.
REQ-029 After reset_n rises, the first clock edge SHALL see imem_req=1, imem_addr=RESET_PC.
REQ-030 Reset asserted mid-request or mid-HOLD SHALL abandon the request and the held instruction; a late imem_ack after reset SHALL be treated as the response to the RESET_PC request (memory is reset alongside).

Verification
REQ-031 Reset release, imem_ack same cycle, rdata=32'h0000_0033, inst_ready=1 -> inst_valid=1 one cycle later with inst_pc=0, next imem_addr=4.
REQ-032 imem_ack delayed 3 cycles -> imem_req=1 and imem_addr=0 stable all 4 cycles, then instruction delivered.
REQ-033 inst_ready=0 for 5 cycles in HOLD -> inst_valid, inst_out, inst_pc stable; imem_req=0 throughout.
REQ-034 redirect=1, redirect_pc=32'h0000_0103 while request to 8 pending -> ack for 8 discarded, next imem_addr=32'h0000_0100, delivered inst_pc=32'h0000_0100.
REQ-035 RESET_PC=32'hFFFF_FFFC, two sequential fetches -> inst_pc sequence FFFF_FFFC, 0000_0000.
REQ-036 reset_n pulsed low while in HOLD -> inst_valid=0 immediately, next fetch at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Single-outstanding-request instruction fetch unit: one request to imem at a time,
// one instruction held for decode, with redirect handling and discard of stale responses.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } held_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_target, pc_target_nxt;
  logic [31:0] redir_tgt;
  logic        capture;
  held_t       held;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    pc_target_nxt = pc_target;
    capture       = 1'b0;
    case (state)
      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_nxt = redir_tgt;
          end else begin
            capture   = 1'b1;
            pc_nxt    = pc + 32'd4;
            state_nxt = S_HOLD;
          end
        end else if (redirect) begin
          // Request stays on the bus with its old address; target waits for the ack.
          pc_target_nxt = redir_tgt;
          state_nxt     = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          pc_nxt    = redirect ? redir_tgt : pc_target;
          state_nxt = S_REQ;
        end else if (redirect) begin
          pc_target_nxt = redir_tgt;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nxt    = redir_tgt;
          state_nxt = S_REQ;
        end else if (inst_ready) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC_AL;
      pc_target <= RESET_PC_AL;
      held      <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      pc_target <= pc_target_nxt;
      if (capture) held <= '{word: imem_rdata, pc: pc};
    end
  end

  // Request is gated by reset so nothing leaks onto the bus while reset is held.
  assign imem_req   = reset_n & (state != S_HOLD);
  assign imem_addr  = pc;
  assign inst_valid = (state == S_HOLD);
  assign inst_out   = held.word;
  assign inst_pc    = held.pc;

endmodule
